dpr_init: RTL and testbench



---
 rtl/dpr_init_pkg.sv | 23 ++
 rtl/dpr_core.sv | 39 +++
 rtl/dpr_init.sv | 142 ++++++++++++++
 tb/tb_dpr_init.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dpr_init_pkg.sv
// Shared types and constants for the dpr_init dual-port RAM with clear engine.
`timescale 1ns/1ps
package dpr_init_pkg;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   // Source of each registered read port: forced zero after reset, array, or bypass.
   typedef enum logic [1:0] {
      OUT_ZERO = 2'd0,
      OUT_RAM  = 2'd1,
      OUT_BYP  = 2'd2
   } out_sel_t;

   localparam int INIT_DEFAULT = 0;

   function automatic int dpr_depth(input int aw);
      return 1 << aw;
   endfunction

endpackage

// File: rtl/dpr_core.sv
// Inferred true dual-port array with registered, read-first read ports and no reset.
`timescale 1ns/1ps
module dpr_core
   import dpr_init_pkg::*;
#(
   parameter int DW = 8,
   parameter int AW = 14
) (
   input  logic          clock,
   input  logic          we_a,
   input  logic          re_a,
   input  logic [AW-1:0] addr_a,
   input  logic [DW-1:0] din_a,
   output logic [DW-1:0] dout_a,
   input  logic          we_b,
   input  logic          re_b,
   input  logic [AW-1:0] addr_b,
   input  logic [DW-1:0] din_b,
   output logic [DW-1:0] dout_b
);

   localparam int DEPTH = dpr_depth(AW);

   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] dout_a_q;
   logic [DW-1:0] dout_b_q;

   // Port A write is placed last so it wins any residual same-address conflict.
   always_ff @(posedge clock) begin
      if (we_b) mem_q[addr_b] <= din_b;
      if (we_a) mem_q[addr_a] <= din_a;
      if (re_a) dout_a_q <= mem_q[addr_a];
      if (re_b) dout_b_q <= mem_q[addr_b];
   end

   assign dout_a = dout_a_q;
   assign dout_b = dout_b_q;

endmodule

// File: rtl/dpr_init.sv
// Dual-port RAM with hardware clear engine and deterministic collision rules.
// Define DPR_INIT_WRITE_THROUGH_EN for cross-port write-through on read/write collisions.
`timescale 1ns/1ps
module dpr_init
   import dpr_init_pkg::*;
#(
   parameter int            DW   = 8,
   parameter int            AW   = 14,
   parameter logic [DW-1:0] INIT = DW'(INIT_DEFAULT)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          clr,
   output logic          busy,
   input  logic          ce_a,
   input  logic          we_a,
   input  logic [AW-1:0] a_a,
   input  logic [DW-1:0] di_a,
   output logic [DW-1:0] do_a,
   input  logic          ce_b,
   input  logic          we_b,
   input  logic [AW-1:0] a_b,
   input  logic [DW-1:0] di_b,
   output logic [DW-1:0] do_b
);

   state_t        state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;
   out_sel_t      sel_a_q, sel_a_d;
   out_sel_t      sel_b_q, sel_b_d;

   logic          run;
   logic          wr_a, rd_a, wr_b, rd_b, same_addr;
   logic          core_we_a, core_re_a, core_we_b, core_re_b;
   logic [AW-1:0] core_addr_a;
   logic [DW-1:0] core_din_a;
   logic [DW-1:0] ram_a, ram_b;

   assign run       = (state_q == ST_RUN);
   assign busy      = ~run;
   assign wr_a      = ce_a & ~we_a;
   assign rd_a      = ce_a &  we_a;
   assign wr_b      = ce_b & ~we_b;
   assign rd_b      = ce_b &  we_b;
   assign same_addr = (a_a == a_b);

   // The clear engine borrows port A's write path; port B loses same-address write races.
   assign core_we_a   = ~run | (run & wr_a);
   assign core_addr_a = run ? a_a  : cnt_q;
   assign core_din_a  = run ? di_a : INIT;
   assign core_re_a   = run & rd_a;
   assign core_we_b   = run & wr_b & ~(wr_a & same_addr);
   assign core_re_b   = run & rd_b;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_CLEAR: begin
            cnt_d = cnt_q + AW'(1);
            if (cnt_q == '1) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (clr) begin
               state_d = ST_CLEAR;
               cnt_d   = '0;
            end
         end
      endcase
   end

   always_comb begin
      sel_a_d = sel_a_q;
      sel_b_d = sel_b_q;
      if (core_re_a) sel_a_d = OUT_RAM;
      if (core_re_b) sel_b_d = OUT_RAM;
`ifdef DPR_INIT_WRITE_THROUGH_EN
      if (core_re_a && core_we_b && same_addr) sel_a_d = OUT_BYP;
      if (core_re_b && wr_a && same_addr)      sel_b_d = OUT_BYP;
`endif
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_CLEAR;
         cnt_q   <= '0;
         sel_a_q <= OUT_ZERO;
         sel_b_q <= OUT_ZERO;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sel_a_q <= sel_a_d;
         sel_b_q <= sel_b_d;
      end
   end

`ifdef DPR_INIT_WRITE_THROUGH_EN
   logic [DW-1:0] byp_a_q, byp_b_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         byp_a_q <= '0;
         byp_b_q <= '0;
      end else begin
         if (core_re_a && core_we_b && same_addr) byp_a_q <= di_b;
         if (core_re_b && wr_a && same_addr)      byp_b_q <= di_a;
      end
   end

   always_comb begin
      do_a = ram_a;
      do_b = ram_b;
      if (sel_a_q == OUT_ZERO)     do_a = '0;
      else if (sel_a_q == OUT_BYP) do_a = byp_a_q;
      if (sel_b_q == OUT_ZERO)     do_b = '0;
      else if (sel_b_q == OUT_BYP) do_b = byp_b_q;
   end
`else
   always_comb begin
      do_a = (sel_a_q == OUT_ZERO) ? '0 : ram_a;
      do_b = (sel_b_q == OUT_ZERO) ? '0 : ram_b;
   end
`endif

   dpr_core #(
      .DW (DW),
      .AW (AW)
   ) u_core (
      .clock  (clock),
      .we_a   (core_we_a),
      .re_a   (core_re_a),
      .addr_a (core_addr_a),
      .din_a  (core_din_a),
      .dout_a (ram_a),
      .we_b   (core_we_b),
      .re_b   (core_re_b),
      .addr_b (a_b),
      .din_b  (di_b),
      .dout_b (ram_b)
   );

endmodule

// File: tb/tb_dpr_init.sv
// Scoreboard bench for dpr_init (AW=4, INIT=8'hA5): reads push expectations, a monitor pops them.
`timescale 1ns/1ps
module tb_dpr_init;

   localparam int            DW   = 8;
   localparam int            AW   = 4;
   localparam logic [DW-1:0] INIT = 8'hA5;
`ifdef DPR_INIT_WRITE_THROUGH_EN
   localparam bit WT = 1'b1;
`else
   localparam bit WT = 1'b0;
`endif

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          clr   = 1'b0;
   logic          busy;
   logic          ce_a  = 1'b0, we_a = 1'b1, ce_b = 1'b0, we_b = 1'b1;
   logic [AW-1:0] a_a   = '0, a_b = '0;
   logic [DW-1:0] di_a  = '0, di_b = '0;
   logic [DW-1:0] do_a, do_b;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [DW-1:0] exp;
      string         name;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];
   exp_t e_a, e_b;

   logic tb_rd_a = 1'b0, tb_rd_b = 1'b0;
   logic rdv_a   = 1'b0, rdv_b   = 1'b0;

   dpr_init #(
      .DW   (DW),
      .AW   (AW),
      .INIT (INIT)
   ) dut (
      .clock (clock),
      .reset (reset),
      .clr   (clr),
      .busy  (busy),
      .ce_a  (ce_a),
      .we_a  (we_a),
      .a_a   (a_a),
      .di_a  (di_a),
      .do_a  (do_a),
      .ce_b  (ce_b),
      .we_b  (we_b),
      .a_b   (a_b),
      .di_b  (di_b),
      .do_b  (do_b)
   );

   always #5 clock = ~clock;

   // A read issued in a cycle is due on do_x after the following rising edge.
   always @(posedge clock) begin
      rdv_a <= tb_rd_a;
      rdv_b <= tb_rd_b;
   end

   always @(negedge clock) begin
      if (rdv_a) begin
         checks++;
         if (q_a.size() == 0) begin
            errors++;
            $display("FAIL unexpected_read_a: do_a=%h with no expectation queued", do_a);
         end else begin
            e_a = q_a.pop_front();
            if (do_a !== e_a.exp) begin
               errors++;
               $display("FAIL %s: do_a=%h expected %h", e_a.name, do_a, e_a.exp);
            end else
               $display("ok   %s: do_a=%h", e_a.name, do_a);
         end
      end
      if (rdv_b) begin
         checks++;
         if (q_b.size() == 0) begin
            errors++;
            $display("FAIL unexpected_read_b: do_b=%h with no expectation queued", do_b);
         end else begin
            e_b = q_b.pop_front();
            if (do_b !== e_b.exp) begin
               errors++;
               $display("FAIL %s: do_b=%h expected %h", e_b.name, do_b, e_b.exp);
            end else
               $display("ok   %s: do_b=%h", e_b.name, do_b);
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else
         $display("ok   %s: %0h", name, act);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      ce_a = 1'b0; we_a = 1'b1;
      ce_b = 1'b0; we_b = 1'b1;
      clr  = 1'b0;
      tb_rd_a = 1'b0;
      tb_rd_b = 1'b0;
   endtask

   task automatic rd_a(input logic [AW-1:0] addr, input logic [DW-1:0] exp, input string name);
      exp_t e;
      ce_a = 1'b1; we_a = 1'b1; a_a = addr; tb_rd_a = 1'b1;
      e.exp = exp; e.name = name;
      q_a.push_back(e);
   endtask

   task automatic rd_b(input logic [AW-1:0] addr, input logic [DW-1:0] exp, input string name);
      exp_t e;
      ce_b = 1'b1; we_b = 1'b1; a_b = addr; tb_rd_b = 1'b1;
      e.exp = exp; e.name = name;
      q_b.push_back(e);
   endtask

   task automatic wr_a(input logic [AW-1:0] addr, input logic [DW-1:0] data);
      ce_a = 1'b1; we_a = 1'b0; a_a = addr; di_a = data; tb_rd_a = 1'b0;
   endtask

   task automatic wr_b(input logic [AW-1:0] addr, input logic [DW-1:0] data);
      ce_b = 1'b1; we_b = 1'b0; a_b = addr; di_b = data; tb_rd_b = 1'b0;
   endtask

   // Counts rising edges from now until busy is seen low; the fill must take 16.
   task automatic measure_fill(input string name);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (busy && n < 100);
      check(name, n, 16);
   endtask

   initial begin
      int n;
      idle();
      reset = 1'b0;
      repeat (3) tick();
      check("busy_in_reset", busy, 1);
      check("do_a_in_reset", do_a, 0);
      check("do_b_in_reset", do_b, 0);

      @(negedge clock);
      reset = 1'b1;
      measure_fill("fill_len_after_reset");

      for (int i = 0; i < 16; i++) begin
         rd_b(AW'(i), INIT, $sformatf("init_rd_b_%0d", i));
         tick();
      end
      idle();
      tick();

      rd_a(4'd0, INIT, "rd_a_0");
      tick(); idle();
      wr_a(4'd3, 8'h12);
      tick(); idle();
      check("do_a_hold_during_write", do_a, 32'hA5);
      rd_b(4'd3, 8'h12, "rd_b_after_wr_a");
      tick(); idle(); tick();

      wr_a(4'd7, 8'h11); wr_b(4'd7, 8'h22);
      tick(); idle();
      rd_a(4'd7, 8'h11, "both_wr_rd_a_7");
      rd_b(4'd7, 8'h11, "both_wr_rd_b_7");
      tick(); idle(); tick();

      wr_a(4'd5, 8'h33);
      rd_b(4'd5, WT ? 8'h33 : 8'hA5, "coll_a_wr_b_rd");
      tick(); idle();
      rd_b(4'd5, 8'h33, "rd_b_5_after_coll");
      tick(); idle(); tick();

      wr_b(4'd6, 8'h55);
      rd_a(4'd6, WT ? 8'h55 : 8'hA5, "coll_b_wr_a_rd");
      tick(); idle();
      rd_a(4'd6, 8'h55, "rd_a_6_after_coll");
      tick(); idle();
      repeat (3) tick();
      check("do_a_hold_ce0", do_a, 32'h55);
      check("do_b_hold_ce0", do_b, 32'h33);

      wr_a(4'd2, 8'h44);
      tick(); idle();
      clr = 1'b1;
      wr_a(4'd10, 8'h77);
      tick(); idle();
      check("busy_after_clr", busy, 1);
      wr_a(4'd9, 8'h99);
      n = 0;
      do begin
         tick();
         n++;
         idle();
         if (n == 4) clr = 1'b1;
      end while (busy && n < 100);
      check("fill_len_after_clr", n, 16);
      rd_a(4'd2, INIT, "rd_a_2_after_clr");
      rd_b(4'd9, INIT, "rd_b_9_after_clr");
      tick(); idle();
      rd_a(4'd10, INIT, "rd_a_10_after_clr");
      tick(); idle(); tick();

      wr_b(4'd7, 8'h5A); wr_a(4'd3, 8'h3C);
      tick(); idle();
      rd_a(4'd3, 8'h3C, "rd_a_3_pre_reset");
      rd_b(4'd7, 8'h5A, "rd_b_7_pre_reset");
      tick(); idle(); tick();
      clr = 1'b1;
      tick(); idle();
      repeat (6) tick();
      check("do_a_hold_busy", do_a, 32'h3C);
      check("do_b_hold_busy", do_b, 32'h5A);
      reset = 1'b0;
      #1;
      check("do_a_async_reset", do_a, 0);
      check("do_b_async_reset", do_b, 0);
      check("busy_async_reset", busy, 1);
      repeat (2) tick();
      @(negedge clock);
      reset = 1'b1;
      measure_fill("fill_len_after_midfill_reset");
      rd_b(4'd7, INIT, "rd_b_7_after_refill");
      rd_a(4'd3, INIT, "rd_a_3_after_refill");
      tick(); idle(); tick();

      check("scoreboard_drained", q_a.size() + q_b.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
